mem_arbiter: RTL and testbench

Shares the single byte-wide main-memory port (port A of the 8-bit true-dual-port BRAM) between two 32-bit requesters using the picorv32 native valid/ready protocol. Requester 0 is the CPU; requester 1 is a secondary master (program loader / blitter). The block grants one requester at a time and serialises each 32-bit word access into four sequential byte accesses. It drives the BRAM address, data and write enable, and returns a completed word with a one-cycle ready pulse.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-serialising main-memory arbiter.
// Imported by mem_arb_pick, mem_arbiter_if and mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_RD_LAT = 2;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two 32-bit valid/ready requesters, the arbiter and BRAM port A.
// The arbiter uses the slave modport; the master modport is the requester/memory side.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
);
    logic                  req0_valid;
    logic [31:0]           req0_addr;
    logic [31:0]           req0_wdata;
    logic [3:0]            req0_wstrb;
    logic                  req0_ready;
    logic [31:0]           req0_rdata;

    logic                  req1_valid;
    logic [31:0]           req1_addr;
    logic [31:0]           req1_wdata;
    logic [3:0]            req1_wstrb;
    logic                  req1_ready;
    logic [31:0]           req1_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_din;
    logic                  mem_we;
    logic [7:0]            mem_dout;

    logic                  busy;
    logic                  grant;

    modport slave (
        input  req0_valid, req0_addr, req0_wdata, req0_wstrb,
        input  req1_valid, req1_addr, req1_wdata, req1_wstrb,
        input  mem_dout,
        output req0_ready, req0_rdata, req1_ready, req1_rdata,
        output mem_addr, mem_din, mem_we,
        output busy, grant
    );

    modport master (
        output req0_valid, req0_addr, req0_wdata, req0_wstrb,
        output req1_valid, req1_addr, req1_wdata, req1_wstrb,
        output mem_dout,
        input  req0_ready, req0_rdata, req1_ready, req1_rdata,
        input  mem_addr, mem_din, mem_we,
        input  busy, grant
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the two requesters.
// MEM_ARB_RR_EN selects round-robin on last_grant; otherwise requester 0 has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_any,
    output logic o_winner
);

    assign o_any = i_valid0 | i_valid1;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        o_winner = i_last_grant;
        if (i_valid0 && i_valid1) begin
            o_winner = ~i_last_grant;
        end else if (i_valid0) begin
            o_winner = 1'b0;
        end else if (i_valid1) begin
            o_winner = 1'b1;
        end
    end
`else
    // With no request pending the winner is a don't-care; it simply follows last_grant.
    always_comb begin
        o_winner = i_last_grant;
        if (i_valid0) begin
            o_winner = 1'b0;
        end else if (i_valid1) begin
            o_winner = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter serialising 32-bit valid/ready accesses onto a byte-wide BRAM port.
// Arbitration policy is set by MEM_ARB_RR_EN inside mem_arb_pick.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int RD_LAT     = DEFAULT_RD_LAT
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam int DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [DRN_W-1:0]      r_drn;
    logic                  r_grant;
    logic                  r_last_grant;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic [7:0]            r_mem_din;
    logic [7:0]            w_mem_din_nxt;
    logic                  r_mem_we;
    logic                  w_mem_we_nxt;

    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [23:0]           r_rbuf;
    logic [31:0]           r_rdata0;
    logic [31:0]           r_rdata1;

    logic [RD_LAT-1:0]     r_rd_vld_p;
    logic [CNT_W-1:0]      r_rd_idx_p [RD_LAT];

    logic                  w_any;
    logic                  w_win;
    logic                  w_take;
    logic                  w_is_read;
    logic                  w_cap;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [31:0]           w_req_wdata;
    logic [3:0]            w_req_wstrb;
    logic                  w_unused;

    mem_arb_pick u_pick (
        .i_valid0     (bus.req0_valid),
        .i_valid1     (bus.req1_valid),
        .i_last_grant (r_last_grant),
        .o_any        (w_any),
        .o_winner     (w_win)
    );

    assign w_req_addr  = w_win ? bus.req1_addr[ADDR_WIDTH-1:0] : bus.req0_addr[ADDR_WIDTH-1:0];
    assign w_req_wdata = w_win ? bus.req1_wdata : bus.req0_wdata;
    assign w_req_wstrb = w_win ? bus.req1_wstrb : bus.req0_wstrb;
    assign w_unused    = ^{bus.req0_addr[31:ADDR_WIDTH], bus.req1_addr[31:ADDR_WIDTH]};

    assign w_is_read = (r_wstrb == 4'b0000);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_cap     = r_rd_vld_p[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the byte lane to present on the BRAM port in the following cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_take         = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_din_nxt  = r_mem_din;
        w_mem_we_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_take         = 1'b1;
                    w_state_nxt    = ACCESS;
                    w_mem_addr_nxt = w_req_addr;
                    w_mem_din_nxt  = w_req_wdata[7:0];
                    w_mem_we_nxt   = w_req_wstrb[0];
                end
            end
            ACCESS: begin
                if (r_cnt == CNT_W'(BYTES_PER_WORD - 1)) begin
                    w_state_nxt = w_is_read ? DRAIN : DONE;
                end else begin
                    w_mem_addr_nxt = r_mem_addr + ADDR_WIDTH'(1);
                    w_mem_din_nxt  = r_wdata[{w_cnt_inc, 3'b000} +: 8];
                    w_mem_we_nxt   = r_wstrb[w_cnt_inc];
                end
            end
            DRAIN: begin
                if (r_drn == DRN_W'(RD_LAT - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_drn        <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_mem_we     <= 1'b0;
            r_rd_vld_p   <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_din  <= w_mem_din_nxt;
            r_mem_we   <= w_mem_we_nxt;

            if (w_take) begin
                r_cnt        <= '0;
                r_grant      <= w_win;
                r_last_grant <= w_win;
            end else if (r_state == ACCESS) begin
                r_cnt <= w_cnt_inc;
            end

            r_drn <= (r_state == DRAIN) ? r_drn + DRN_W'(1) : '0;

            // Tags each presented read byte so it is caught RD_LAT cycles later.
            r_rd_vld_p[0] <= (r_state == ACCESS) && w_is_read;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_vld_p[i] <= r_rd_vld_p[i-1];
            end

            // The word is published only when its last byte lands, so rdata never shows a partial word.
            if (w_cap && (r_rd_idx_p[RD_LAT-1] == CNT_W'(BYTES_PER_WORD - 1))) begin
                if (r_grant) begin
                    r_rdata1 <= {bus.mem_dout, r_rbuf};
                end else begin
                    r_rdata0 <= {bus.mem_dout, r_rbuf};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_take) begin
            r_wdata <= w_req_wdata;
            r_wstrb <= w_req_wstrb;
        end

        r_rd_idx_p[0] <= r_cnt;
        for (int i = 1; i < RD_LAT; i++) begin
            r_rd_idx_p[i] <= r_rd_idx_p[i-1];
        end

        if (w_cap) begin
            case (r_rd_idx_p[RD_LAT-1])
                2'd0:    r_rbuf[7:0]   <= bus.mem_dout;
                2'd1:    r_rbuf[15:8]  <= bus.mem_dout;
                2'd2:    r_rbuf[23:16] <= bus.mem_dout;
                default: r_rbuf        <= r_rbuf;
            endcase
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign bus.mem_we     = r_mem_we;
    assign bus.busy       = (r_state != IDLE);
    assign bus.grant      = r_grant;
    assign bus.req0_ready = (r_state == DONE) && !r_grant;
    assign bus.req1_ready = (r_state == DONE) && r_grant;
    assign bus.req0_rdata = r_rdata0;
    assign bus.req1_rdata = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a two-cycle-latency byte BRAM model on port A.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    mem_arbiter_if #(.ADDR_WIDTH(17)) bus ();

    mem_arbiter #(.ADDR_WIDTH(17), .RD_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:(1<<17)-1];
    logic [7:0]  r_d1;
    logic [7:0]  r_d2;
    logic        pl_we;
    logic [16:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_din;
        end
        r_d1 <= mem[bus.mem_addr];
        r_d2 <= r_d1;
    end
    assign bus.mem_dout = r_d2;

    int          checks = 0;
    int          errors = 0;
    int          rdy_cyc;
    logic        wrong_rdy;
    logic [31:0] we_log;
    logic [31:0] rdata_obs;
    logic [16:0] addr_log [4];
    logic        grant_c1;
    logic        busy_c1;
    logic        flag;
    int          npulse;
    int          who  [4];
    int          pcyc [4];
    logic [31:0] prd  [4];
    int          exp_who;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Starts one transaction in the next IDLE cycle (cycle 0) and follows it until its ready.
    task automatic txn(input int req, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
        tick();
        if (req == 0) begin
            bus.req0_valid = 1'b1; bus.req0_addr = addr; bus.req0_wdata = wdata; bus.req0_wstrb = wstrb;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_addr = addr; bus.req1_wdata = wdata; bus.req1_wstrb = wstrb;
        end
        rdy_cyc   = -1;
        wrong_rdy = 1'b0;
        we_log    = '0;
        rdata_obs = '0;
        for (int c = 1; c <= 20 && rdy_cyc < 0; c++) begin
            tick();
            if (c <= 4) addr_log[c-1] = bus.mem_addr;
            if (c == 1) begin
                grant_c1 = bus.grant;
                busy_c1  = bus.busy;
            end
            we_log[c] = bus.mem_we;
            if ((req == 0) ? bus.req1_ready : bus.req0_ready) wrong_rdy = 1'b1;
            if ((req == 0) ? bus.req0_ready : bus.req1_ready) begin
                rdy_cyc        = c;
                rdata_obs      = (req == 0) ? bus.req0_rdata : bus.req1_rdata;
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        pl_we          = 1'b0;
        pl_addr        = '0;
        pl_data        = '0;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_wstrb = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_wstrb = '0;
        tick();
        tick();
        check("rst_busy",   bus.busy,       32'd0);
        check("rst_grant",  bus.grant,      32'd0);
        check("rst_we",     bus.mem_we,     32'd0);
        check("rst_addr",   bus.mem_addr,   32'd0);
        check("rst_ready",  {bus.req0_ready, bus.req1_ready}, 32'd0);
        check("rst_rdata0", bus.req0_rdata, 32'd0);

        for (int i = 0; i < 4; i++) preload(17'h10000 + 17'(i), 8'h11 * 8'(i + 1));
        for (int i = 0; i < 4; i++) preload(17'h00200 + 17'(i), 8'(i + 1));
        for (int i = 0; i < 4; i++) preload(17'h00300 + 17'(i), 8'hE0 + 8'(i));
        preload(17'h1FFFE, 8'hA1);
        preload(17'h1FFFF, 8'hB2);
        preload(17'h00000, 8'hC3);
        preload(17'h00001, 8'hD4);
        rst = 1'b0;

        // Single read by requester 0
        txn(0, 32'h0001_0000, 32'h0, 4'b0000);
        check("rd_ready_cyc", rdy_cyc,   32'd7);
        check("rd_rdata",     rdata_obs, 32'h4433_2211);
        check("rd_no_we",     we_log,    32'h0);
        for (int i = 0; i < 4; i++) check($sformatf("rd_addr%0d", i), addr_log[i], 32'h10000 + i);
        check("rd_grant",     grant_c1,  32'd0);
        check("rd_busy",      busy_c1,   32'd1);
        check("rd_other_rdy", wrong_rdy, 32'd0);
        tick();
        check("rd_idle_busy", bus.busy,       32'd0);
        check("rd_hold",      bus.req0_rdata, 32'h4433_2211);

        // Masked write by requester 1
        txn(1, 32'h0000_0200, 32'hAABB_CCDD, 4'b0101);
        check("wr_ready_cyc", rdy_cyc,        32'd5);
        check("wr_we_cycles", we_log,         32'h0000_000A);
        check("wr_grant",     grant_c1,       32'd1);
        check("wr_other_rdy", wrong_rdy,      32'd0);
        check("wr_addr3",     addr_log[3],    32'h203);
        check("wr_rdata1",    bus.req1_rdata, 32'h0);
        check("wr_rdata0",    bus.req0_rdata, 32'h4433_2211);

        txn(0, 32'h0000_0200, 32'h0, 4'b0000);
        check("wr_readback",  rdata_obs,      32'h04BB_02DD);

        // Address wrap, with bits above the BRAM width set
        txn(0, 32'h0003_FFFE, 32'h0, 4'b0000);
        check("wrap_addr0", addr_log[0], 32'h1FFFE);
        check("wrap_addr1", addr_log[1], 32'h1FFFF);
        check("wrap_addr2", addr_log[2], 32'h00000);
        check("wrap_addr3", addr_log[3], 32'h00001);
        check("wrap_rdata", rdata_obs,   32'hD4C3_B2A1);

        // Reset during a full-strobe write by requester 1
        tick();
        tick();
        bus.req1_valid = 1'b1; bus.req1_addr = 32'h300; bus.req1_wdata = 32'h5566_7788; bus.req1_wstrb = 4'b1111;
        tick();
        check("rstw_c1_we",    bus.mem_we, 32'd1);
        check("rstw_c1_grant", bus.grant,  32'd1);
        rst            = 1'b1;
        bus.req1_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rstw_busy",   bus.busy,       32'd0);
        check("rstw_grant",  bus.grant,      32'd0);
        check("rstw_we",     bus.mem_we,     32'd0);
        check("rstw_addr",   bus.mem_addr,   32'd0);
        check("rstw_din",    bus.mem_din,    32'd0);
        check("rstw_rdata0", bus.req0_rdata, 32'd0);
        check("rstw_ready",  {bus.req0_ready, bus.req1_ready}, 32'd0);
        flag = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.req0_ready || bus.req1_ready || bus.busy || bus.mem_we) flag = 1'b1;
        end
        check("rstw_quiet", flag,         32'd0);
        check("rstw_b0",    mem[17'h300], 32'h88);
        check("rstw_b1",    mem[17'h301], 32'hE1);
        check("rstw_b2",    mem[17'h302], 32'hE2);
        check("rstw_b3",    mem[17'h303], 32'hE3);
        txn(0, 32'h0000_0300, 32'h0, 4'b0000);
        check("rstw_after_cyc",   rdy_cyc,   32'd7);
        check("rstw_after_rdata", rdata_obs, 32'hE3E2_E188);

        // Both requesters held valid continuously
        do_reset();
        tick();
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h0001_0000; bus.req0_wstrb = 4'b0000;
        bus.req1_valid = 1'b1; bus.req1_addr = 32'h0001_FFFE; bus.req1_wstrb = 4'b0000;
        npulse = 0;
        for (int i = 0; i < 4; i++) begin
            who[i] = -1; pcyc[i] = -1; prd[i] = '0;
        end
        for (int c = 1; c <= 60 && npulse < 4; c++) begin
            tick();
            if (bus.req0_ready || bus.req1_ready) begin
                who[npulse]  = (bus.req0_ready && bus.req1_ready) ? 2 : (bus.req1_ready ? 1 : 0);
                pcyc[npulse] = c;
                prd[npulse]  = bus.req1_ready ? bus.req1_rdata : bus.req0_rdata;
                npulse++;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("sim_npulse", npulse, 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_who = i % 2;
`else
            exp_who = 0;
`endif
            check($sformatf("sim_who%0d", i),   who[i],  exp_who);
            check($sformatf("sim_cyc%0d", i),   pcyc[i], 7 + 8 * i);
            check($sformatf("sim_rdata%0d", i), prd[i],  (exp_who == 0) ? 32'h4433_2211 : 32'hD4C3_B2A1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
